// File: rtl/barrett_mod_sched.sv
// barrett_mod_sched: serial mu precompute for modulus q, then a 3-stage
// valid/ready Barrett reduction pipeline with tag pass-through.
module barrett_mod_sched #(
  parameter int K     = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [K-1:0]     cfg_q,
  output logic             cfg_err,
  output logic             mod_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*K-1:0]   in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;
  localparam int CW = $clog2(2*K+2);

  state_t           r_state;
  logic [K-1:0]     r_q;
  logic [K+1:0]     r_mu;
  logic [K+1:0]     r_quo;
  logic [K:0]       r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_mod_ready;
  logic             r_cfg_err;

  logic             r_v1, r_v2, r_v3;
  logic [K+1:0]     r_xl1;
  logic [K+1:0]     r_q3;
  logic [TAG_W-1:0] r_t1, r_t2, r_t3;
  logic [K+1:0]     r_r1;
  logic [K-1:0]     r_r;

  logic             w_empty, w_cfg_ready, w_cfg_hs;
  logic             w_adv, w_in_ready, w_in_hs;
  logic             w_bit, w_ge;
  logic [K:0]       w_rem_sh, w_rem_nx;
  logic [K+1:0]     w_quo_nx;
  logic [K:0]       w_q1;
  logic [2*K+2:0]   w_p;
  logic [K+1:0]     w_q3q, w_r1, w_2q, w_qe, w_r;
  logic             w_unused;

  assign w_empty     = !r_v1 && !r_v2 && !r_v3;
  assign w_cfg_ready = (r_state == IDLE) || ((r_state == RUN) && w_empty);
  assign w_cfg_hs    = cfg_valid && w_cfg_ready;
  assign w_adv       = !r_v3 || out_ready;
  assign w_in_ready  = r_mod_ready && w_adv && !w_cfg_hs;
  assign w_in_hs     = in_valid && w_in_ready;

  // Dividend is 1 followed by 2K zeros, fed MSB first
  assign w_bit    = (r_cnt == CW'(2*K+1));
  assign w_rem_sh = {r_rem[K-1:0], w_bit};
  assign w_ge     = w_rem_sh >= {1'b0, r_q};
  assign w_rem_nx = w_ge ? w_rem_sh - {1'b0, r_q} : w_rem_sh;
  assign w_quo_nx = {r_quo[K:0], w_ge};

  assign w_q1  = in_x[2*K-1:K-1];
  assign w_p   = (2*K+3)'(w_q1) * (2*K+3)'(r_mu);
  assign w_qe  = {2'b00, r_q};
  assign w_2q  = {1'b0, r_q, 1'b0};
  assign w_q3q = r_q3 * w_qe;
  assign w_r1  = r_xl1 - w_q3q;

  always_comb begin
    w_r = r_r1;
    unique case (1'b1)
      (r_r1 >= w_2q): w_r = r_r1 - w_2q;
      (r_r1 <  w_2q) && (r_r1 >= w_qe): w_r = r_r1 - w_qe;
      default: w_r = r_r1;
    endcase
  end

  assign w_unused = ^{r_quo[K+1], r_rem[K], w_p[K:0], w_r[K+1:K]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_mu        <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_mod_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (w_cfg_hs) begin
        r_mod_ready <= 1'b0;
        if (!cfg_q[K-1]) begin
          r_state   <= IDLE;
          r_cfg_err <= 1'b1;
        end else begin
          r_q     <= cfg_q;
          r_rem   <= '0;
          r_quo   <= '0;
          r_cnt   <= CW'(2*K+1);
          r_state <= DIV;
        end
      end else if (r_state == DIV) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_mu        <= w_quo_nx;
          r_state     <= RUN;
          r_mod_ready <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_xl1 <= '0;
      r_q3  <= '0;
      r_t1  <= '0;
      r_t2  <= '0;
      r_t3  <= '0;
      r_r1  <= '0;
      r_r   <= '0;
    end else if (w_adv) begin
      r_v1 <= w_in_hs;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (w_in_hs) begin
        r_xl1 <= in_x[K+1:0];
        r_q3  <= w_p[2*K+2:K+1];
        r_t1  <= in_tag;
      end
      if (r_v1) begin
        r_r1 <= w_r1;
        r_t2 <= r_t1;
      end
      if (r_v2) begin
        r_r  <= w_r[K-1:0];
        r_t3 <= r_t2;
      end
    end
  end

  assign cfg_ready = w_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign mod_ready = r_mod_ready;
  assign in_ready  = w_in_ready;
  assign out_valid = r_v3;
  assign out_r     = r_r;
  assign out_tag   = r_t3;

endmodule

// File: tb/tb_barrett_mod_sched.sv
// tb_barrett_mod_sched: vector table, directed corner sequences and
// random traffic checked against plain x % q arithmetic.
module tb_barrett_mod_sched;
  localparam int K  = 32;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [K-1:0]  cfg_q = '0;
  logic          cfg_err;
  logic          mod_ready;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*K-1:0] in_x = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_r;
  logic [TW-1:0] out_tag;

  barrett_mod_sched #(.K(K), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_q(cfg_q), .cfg_err(cfg_err), .mod_ready(mod_ready),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int or_mode = 0;
  logic [K-1:0] mq = '0;

  typedef struct packed {
    logic [K-1:0]  r;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [2*K-1:0] x;
    logic [TW-1:0]  tag;
    logic [K-1:0]   r;
  } vec_t;

  exp_t expq[$];
  int   push_cyc[$];
  int   pop_cyc[$];

  function automatic void chk(string nm, logic [67:0] act, logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      expq.delete();
    end else if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("out_r", out_r, e.r);
        chk("out_tag", out_tag, e.tag);
        pop_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [K-1:0] model_mod(logic [2*K-1:0] x, logic [K-1:0] q);
    logic [2*K-1:0] r;
    r = x % {32'b0, q};
    return r[K-1:0];
  endfunction

  task automatic send(input logic [2*K-1:0] x, input logic [TW-1:0] tg,
                      input logic [K-1:0] r);
    in_valid = 1'b1;
    in_x = x;
    in_tag = tg;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        expq.push_back(exp_t'{r: r, tag: tg});
        push_cyc.push_back(cyc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expq.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("drain_timeout", expq.size(), 0);
  endtask

  task automatic cfg_hs(input logic [K-1:0] q);
    bit got;
    got = 0;
    cfg_valid = 1'b1;
    cfg_q = q;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1;
        chk("cfg_prio_in_ready", in_ready, 0);
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("cfg_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic good_cfg(input logic [K-1:0] q);
    int busy, rise;
    logic [64:0] one;
    busy = 0;
    rise = -1;
    one = 65'h1_0000_0000_0000_0000;
    cfg_hs(q);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (mod_ready) begin
        rise = i;
        chk("in_ready_at_rise", in_ready, 1);
        break;
      end
      if (!cfg_ready) busy++;
    end
    chk("div_busy_cycles", busy, 65);
    chk("mod_ready_rise_cycle", rise, 66);
    chk("mu", dut.r_mu, one / {33'b0, q});
    mq = q;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mod_ready", mod_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic rand_burst(input int n);
    logic [2*K-1:0] x;
    for (int i = 0; i < n; i++) begin
      x = {$urandom, $urandom};
      if (i % 5 == 1) x = {32'b0, $urandom};
      send(x, TW'(i), model_mod(x, mq));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*K-1:0] x;
    int base;
    tbl[0] = '{64'h0,                     8'd1, 32'h0};
    tbl[1] = '{64'hFFFF_FFFB,             8'd2, 32'h0};
    tbl[2] = '{64'hFFFF_FFF4_0000_0024,   8'd3, 32'h1};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF,   8'd4, 32'd24};
    tbl[4] = '{64'hFFFF_FFFA,             8'd5, 32'hFFFF_FFFA};
    tbl[5] = '{64'h1_0000_0000,           8'd6, 32'd5};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cfg_ready", cfg_ready, 1);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_mod_ready", mod_ready, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_r", out_r, 0);
    chk("reset_out_tag", out_tag, 0);
    @(posedge clk); #1;

    good_cfg(32'hFFFF_FFFB);
    push_cyc.delete();
    pop_cyc.delete();
    for (int i = 0; i < 6; i++) send(tbl[i].x, tbl[i].tag, tbl[i].r);
    drain();
    chk("table_pops", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("latency", pop_cyc[i] - push_cyc[i], 3);
        chk("throughput", pop_cyc[i] - pop_cyc[0], i);
      end
    end

    or_mode = 2;
    rand_burst(40);
    drain();
    or_mode = 0;

    good_cfg(32'h8000_0000);
    send(64'h1234_5678_9ABC_DEF0, 8'h55, 32'h1ABC_DEF0);
    x = {$urandom, $urandom};
    send(x, 8'h56, model_mod(x, mq));
    drain();

    cfg_hs(32'h7FFF_FFFF);
    @(negedge clk);
    chk("bad_cfg_err", cfg_err, 1);
    chk("bad_mod_ready", mod_ready, 0);
    chk("bad_in_ready", in_ready, 0);
    chk("bad_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    chk("bad_cfg_err_pulse", cfg_err, 0);
    chk("bad_in_ready_hold", in_ready, 0);
    @(posedge clk); #1;
    good_cfg(32'hFFFF_FFFB);
    rand_burst(6);
    drain();

    or_mode = 1;
    base = pop_cyc.size();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom};
      send(x, TW'(8'hA0 + i), model_mod(x, mq));
    end
    x = {$urandom, $urandom};
    in_valid = 1'b1;
    in_x = x;
    in_tag = 8'hA3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_r", out_r, expq[0].r);
      chk("stall_out_tag", out_tag, expq[0].tag);
      @(posedge clk); #1;
    end
    or_mode = 0;
    send(x, 8'hA3, model_mod(x, mq));
    drain();
    chk("stall_no_loss", pop_cyc.size() - base, 4);

    cfg_hs(32'h8000_0000 | $urandom);
    repeat (29) @(posedge clk);
    #1;
    do_reset();
    good_cfg(32'h8000_0000 | $urandom);
    or_mode = 2;
    rand_burst(10);
    drain();

    or_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom};
      send(x, TW'(8'hC0 + i), model_mod(x, mq));
    end
    do_reset();
    or_mode = 0;
    good_cfg(32'hFFFF_FFFB);
    rand_burst(8);
    drain();
    chk("final_queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
